sensor_channel_mux: RTL
=======================

Name: sensor_channel_mux

Overview:
- Parametrised, registered N-channel sample multiplexer.
- Selects one of CHANNELS sensor streams, each WIDTH bits wide, and forwards it to a single downstream consumer using a valid/ready handshake.
- Two modes: fixed channel select, and round-robin scan across all channels.
- Sits between the per-sensor front ends and the shared monitor/alarm datapath; successor to the combinational 8-bit 2:1 select.

Parameters:
- WIDTH, 8, sample width in bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, channel index width; must equal ceil(log2(CHANNELS)), minimum 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_data  in  CHANNELS*WIDTH  packed samples; channel i occupies bits [i*WIDTH +: WIDTH].
- ch_valid  in  CHANNELS  per-channel sample valid.
- ch_ready  out  CHANNELS  per-channel accept; combinational; at most one bit set.
- mode  in  1  0 = fixed select, 1 = round-robin scan.
- sel  in  SEL_W  channel index used in fixed mode.
- out_data  out  WIDTH  registered selected sample.
- out_ch  out  SEL_W  index of the channel out_data came from.
- out_valid  out  1  output holds a sample.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_ch=0, rr_ptr=0, all ch_ready=0.
- Single output register; can_load = !out_valid | out_ready. Full throughput of 1 sample/cycle while out_ready stays high.
- Fixed mode:
  - ch_ready[sel] = can_load; all other bits 0.
  - A sample is accepted when ch_valid[sel] & ch_ready[sel].
  - If sel >= CHANNELS, nothing is accepted and ch_ready = 0.
- Round-robin mode:
  - grant = first index g scanning rr_ptr, rr_ptr+1, ... modulo CHANNELS with ch_valid[g]=1.
  - ch_ready[g] = can_load.
  - On accept, rr_ptr <= g+1, wrapping CHANNELS-1 -> 0.
  - If no channel is valid, there is no grant and rr_ptr holds.
- Accept: out_data <= selected sample, out_ch <= its index, out_valid <= 1 at the next edge. Latency 1 cycle.
- Handshake out_valid & out_ready with no new accept: out_valid <= 0 next edge. out_data and out_ch hold their last values.
- Stall (out_valid & !out_ready): out_data, out_ch and out_valid are frozen; ch_ready = 0.
- mode and sel are sampled combinationally each cycle. A change affects only the next accept; a held output sample is never altered.
- Switching from mode 1 to mode 0 leaves rr_ptr unchanged. Returning to mode 1 resumes from the stored rr_ptr.
- Simultaneous downstream pop and upstream accept in the same cycle: the new sample replaces the old one, out_valid stays 1, and nothing is lost or duplicated.
- Reset asserted mid-stall: the held sample is discarded and the block returns to reset values.

Optional Feature:
- Macro: SENSOR_MUX_SEQ_EN.
- When defined:
  - Adds output out_seq [7:0], an 8-bit count of accepted samples.
  - Resets to 0, increments on every accept, wraps 255 -> 0.
  - Captured alongside out_data, so out_seq for the first sample = 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset then fixed mode, sel=2, ch_valid=4'b0100, ch_data ch2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_ch=2; ch_ready=4'b0100 only.
2. Fixed mode, out_ready=0 with a valid sample held; change ch2 data to 8'h3C -> out_data stays A5, ch_ready=0; raise out_ready -> 3C appears the following cycle.
3. Round-robin, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, one sample per cycle.
4. Round-robin with rr_ptr=3 and only ch1 valid -> ch1 granted, rr_ptr becomes 2; then only ch0 and ch3 valid -> ch3 granted first, then ch0 (wrap).
5. Assert rst while out_valid=1 and out_ready=0 -> out_valid, out_data and out_ch go to 0 without waiting for a clock edge.
6. With SENSOR_MUX_SEQ_EN defined, accept 257 samples -> out_seq on the last sample is 0 (wrap), and on the 256th sample is 255.

Source files
------------

// File: rtl/sensor_channel_mux.sv
// sensor_channel_mux
// Registered N-channel sample multiplexer between the per-sensor front ends
// and the shared monitor/alarm datapath. Forwards one channel per accepted
// sample over a valid/ready handshake, either from a fixed channel index
// (mode=0) or by round-robin scan over the valid channels (mode=1).
// A single output register gives one cycle of latency and full throughput
// while out_ready stays high.
//
// Optional build macro: SENSOR_MUX_SEQ_EN
//   When defined, adds out_seq[7:0], an 8-bit wrapping count of accepted
//   samples that is captured together with out_data (first sample carries 0).

module sensor_channel_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    input  logic [CHANNELS-1:0]       ch_valid,
    output logic [CHANNELS-1:0]       ch_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef SENSOR_MUX_SEQ_EN
    ,
    output logic [7:0]                out_seq
`endif
);

    // Channel count widened by one bit so it can be compared against
    // indices even when CHANNELS is an exact power of two.
    localparam logic [SEL_W:0]   CH_CNT  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

    // ---- stage p0: combinational select / grant ----
    logic [WIDTH-1:0] sample_p0 [CHANNELS];
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_grant_p0;
    logic             rr_hit_p0;
    logic [SEL_W:0]   rr_cand_p0;
    logic [SEL_W-1:0] rr_next_p0;
    logic             sel_ok_p0;
    logic [SEL_W-1:0] grant_p0;
    logic             grant_ok_p0;
    logic             can_load_p0;
    logic             accept_p0;

    // ---- stage p1: output register ----
    logic [WIDTH-1:0] data_p1;
    logic [SEL_W-1:0] ch_p1;
    logic             vld_p1;

    // Unpack the flat sample bus so channels can be indexed directly.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign sample_p0[i] = ch_data[i*WIDTH +: WIDTH];
    end

    // Round-robin search: first valid channel starting at rr_ptr, wrapping.
    always_comb begin
        rr_hit_p0   = 1'b0;
        rr_grant_p0 = '0;
        rr_cand_p0  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            rr_cand_p0 = {1'b0, rr_ptr} + (SEL_W+1)'(k);
            if (rr_cand_p0 >= CH_CNT) begin
                rr_cand_p0 = rr_cand_p0 - CH_CNT;
            end
            if (!rr_hit_p0 && ch_valid[rr_cand_p0[SEL_W-1:0]]) begin
                rr_hit_p0   = 1'b1;
                rr_grant_p0 = rr_cand_p0[SEL_W-1:0];
            end
        end
    end

    // Pointer advance after a round-robin grant, wrapping at the last channel.
    always_comb begin
        if (rr_grant_p0 == CH_LAST) begin
            rr_next_p0 = '0;
        end else begin
            rr_next_p0 = rr_grant_p0 + SEL_W'(1);
        end
    end

    // Mode mux: which channel is offered the slot this cycle, and whether
    // any channel is offered at all. An out-of-range fixed index offers none.
    always_comb begin
        sel_ok_p0   = ({1'b0, sel} < CH_CNT);
        can_load_p0 = !vld_p1 || out_ready;
        if (mode) begin
            grant_p0    = rr_grant_p0;
            grant_ok_p0 = rr_hit_p0;
        end else begin
            grant_p0    = sel;
            grant_ok_p0 = sel_ok_p0;
        end
    end

    // One-hot ready towards the granted channel; silent while in reset.
    always_comb begin
        ch_ready  = '0;
        accept_p0 = 1'b0;
        if (!rst && grant_ok_p0 && can_load_p0) begin
            ch_ready[grant_p0] = 1'b1;
            accept_p0          = ch_valid[grant_p0];
        end
    end

    // Control state: output valid flag and round-robin pointer. A pop without
    // a new accept empties the register; a stall leaves it untouched because
    // can_load is low and no accept can happen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            rr_ptr <= '0;
        end else begin
            if (accept_p0) begin
                vld_p1 <= 1'b1;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (accept_p0 && mode) begin
                rr_ptr <= rr_next_p0;
            end
        end
    end

    // Output sample and source index; loaded only on accept, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p1 <= '0;
            ch_p1   <= '0;
        end else if (accept_p0) begin
            data_p1 <= sample_p0[grant_p0];
            ch_p1   <= grant_p0;
        end
    end

`ifdef SENSOR_MUX_SEQ_EN
    logic [7:0] seq_cnt;
    logic [7:0] seq_p1;

    // Accept counter; the pre-increment value travels with the sample so the
    // first accepted sample is tagged 0. Wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_cnt <= '0;
            seq_p1  <= '0;
        end else if (accept_p0) begin
            seq_cnt <= seq_cnt + 8'd1;
            seq_p1  <= seq_cnt;
        end
    end

    assign out_seq = seq_p1;
`endif

    assign out_data  = data_p1;
    assign out_ch    = ch_p1;
    assign out_valid = vld_p1;

endmodule
